sprite_dma_scheduler: RTL and testbench

//  Shares the single synchronous font-glyph ROM among SPR_CNT sprite engines during h-blanking.

---
 rtl/sprite_dma_pkg.sv | 39 +++
 rtl/sprite_rr_arbiter.sv | 38 +++
 rtl/sprite_dma_scheduler.sv | 148 ++++++++++++++
 tb/tb_sprite_dma_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_dma_pkg.sv
// rtl/sprite_dma_pkg.sv - shared types and round-robin pick helper for the sprite DMA scheduler
package sprite_dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    DRAIN  = 2'd2
  } dma_state_t;

  localparam int unsigned MAX_SPR = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of mask at or above ptr, wrapping within the low n bits.
  function automatic rr_pick_t rr_pick(input logic [MAX_SPR-1:0] mask,
                                       input logic [3:0]         ptr,
                                       input int                 n);
    rr_pick_t   r;
    int         j;
    logic [3:0] j4;
    r = '0;
    for (int i = MAX_SPR - 1; i >= 0; i--) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        j4 = j[3:0];
        if (mask[j4]) begin
          r.found = 1'b1;
          r.idx   = j4;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_rr_arbiter.sv
// rtl/sprite_rr_arbiter.sv - combinational round-robin pick over a pending mask
// The pointer moves past the winner only when the caller consumes the grant.
module sprite_rr_arbiter
  import sprite_dma_pkg::*;
#(
  parameter int SPR_CNT = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [SPR_CNT-1:0] mask_i,
  input  logic               advance_i,
  output logic               found_o,
  output logic [3:0]         idx_o
);

  logic [3:0]         ptr_q, ptr_d;
  logic [MAX_SPR-1:0] mask_ext;
  rr_pick_t           pick;

  assign mask_ext = MAX_SPR'(mask_i);
  assign pick     = rr_pick(mask_ext, ptr_q, SPR_CNT);
  assign found_o  = pick.found;
  assign idx_o    = pick.idx;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && pick.found) begin
      if (int'(pick.idx) == SPR_CNT - 1) ptr_d = 4'd0;
      else                               ptr_d = pick.idx + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= 4'd0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sprite_dma_scheduler.sv
// rtl/sprite_dma_scheduler.sv - shares the font ROM among sprite engines during h-blanking
// Requests are latched at window open, granted round-robin one per cycle, responses returned one-hot.
module sprite_dma_scheduler
  import sprite_dma_pkg::*;
#(
  parameter int SPR_CNT     = 4,
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int DMA_START   = -8,
  parameter int WINDOW_LEN  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          pixel_clock,
  input  logic                          reset,
  input  logic signed [COORD_WIDTH-1:0] x,
  input  logic [SPR_CNT-1:0]            req,
  input  logic [SPR_CNT*ADDR_WIDTH-1:0] req_addr,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
  output logic [SPR_CNT-1:0]            grant,
  output logic [SPR_CNT-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          overrun
);

  localparam int WIN_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int DRN_W = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
  localparam logic [WIN_W-1:0]       LAST_WIN   = WIN_W'(WINDOW_LEN - 1);
  localparam logic [DRN_W-1:0]       LAST_DRAIN = DRN_W'(ROM_LATENCY);
  localparam logic [COORD_WIDTH-1:0] START_X    = COORD_WIDTH'(DMA_START);

  dma_state_t              state_q, state_d;
  logic [SPR_CNT-1:0]      pending_q, pending_d;
  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic [SPR_CNT-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic                    overrun_q, overrun_d;
  logic [SPR_CNT-1:0]      rsp_pipe_q [ROM_LATENCY];

  logic                    pick_found;
  logic [3:0]              pick_idx;
  logic [SPR_CNT-1:0]      pick_onehot;
  logic                    advance;
  logic [ADDR_WIDTH-1:0]   addr_arr [MAX_SPR];

  // Padded to 16 entries so the 4-bit pick index selects without width games.
  always_comb begin
    for (int i = 0; i < MAX_SPR; i++) addr_arr[i] = '0;
    for (int i = 0; i < SPR_CNT; i++) addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  sprite_rr_arbiter #(
    .SPR_CNT (SPR_CNT)
  ) u_arb (
    .clk_i     (pixel_clock),
    .reset_i   (reset),
    .mask_i    (pending_q),
    .advance_i (advance),
    .found_o   (pick_found),
    .idx_o     (pick_idx)
  );

  assign pick_onehot = SPR_CNT'(1) << pick_idx;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    win_cnt_d   = win_cnt_q;
    drain_cnt_d = drain_cnt_q;
    grant_d     = '0;
    rom_addr_d  = '0;
    overrun_d   = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (x == START_X) begin
          pending_d = req;
          win_cnt_d = '0;
          state_d   = WINDOW;
        end
      end
      WINDOW: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (pick_found) begin
          advance    = 1'b1;
          grant_d    = pick_onehot;
          rom_addr_d = addr_arr[pick_idx];
          pending_d  = pending_q & ~pick_onehot;
        end
        if (pending_d == '0) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (win_cnt_q == LAST_WIN) begin
          overrun_d   = 1'b1;
          pending_d   = '0;
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == LAST_DRAIN) state_d = IDLE;
        else                           drain_cnt_d = drain_cnt_q + DRN_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      win_cnt_q   <= '0;
      drain_cnt_q <= '0;
      grant_q     <= '0;
      rom_addr_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      win_cnt_q   <= win_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      grant_q     <= grant_d;
      rom_addr_q  <= rom_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  // Grant tracks the ROM read through its latency; reset drops reads in flight.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) rsp_pipe_q[i] <= '0;
    end else begin
      rsp_pipe_q[0] <= grant_q;
      for (int i = 1; i < ROM_LATENCY; i++) rsp_pipe_q[i] <= rsp_pipe_q[i-1];
    end
  end

  assign rom_addr  = rom_addr_q;
  assign grant     = grant_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_pipe_q[ROM_LATENCY-1];
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_dma_scheduler.sv
// tb/tb_sprite_dma_scheduler.sv - scoreboard bench for sprite_dma_scheduler
module tb_sprite_dma_scheduler;

  localparam int N = 4, AW = 9, DW = 8, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [CW-1:0] x;
  logic [N-1:0]         req, req3;
  logic [N*AW-1:0]      req_addr;
  logic [AW-1:0]        rom_addr, rom_addr3;
  logic [DW-1:0]        rom_data, rom_data3, rsp_data, rsp_data3;
  logic [N-1:0]         grant, grant3, rsp_valid, rsp_valid3;
  logic                 busy, busy3, overrun, overrun3;

  sprite_dma_scheduler dut (
    .pixel_clock(clk), .reset(rst), .x(x), .req(req), .req_addr(req_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .overrun(overrun));

  sprite_dma_scheduler #(.WINDOW_LEN(3)) dut3 (
    .pixel_clock(clk), .reset(rst), .x(x), .req(req3), .req_addr(req_addr),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .grant(grant3), .rsp_valid(rsp_valid3),
    .rsp_data(rsp_data3), .busy(busy3), .overrun(overrun3));

  function automatic logic [7:0] rom_f(input logic [8:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    rom_data  <= rom_f(rom_addr);
    rom_data3 <= rom_f(rom_addr3);
  end

  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b0;
  logic [15:0] eg[$], er[$], eg3[$], er3[$];
  int eb[$];
  int busy_run = 0, ovr_seen = 0, ovr3_seen = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] sp_addr(input int s);
    return 9'(8 * (s + 1));
  endfunction

  task automatic exp_g(input int s, input bit with_rsp, input bit on3);
    logic [15:0] g, r;
    g = {4'(1 << s), 3'b0, sp_addr(s)};
    r = {4'(1 << s), 4'b0, rom_f(sp_addr(s))};
    if (on3) begin eg3.push_back(g); if (with_rsp) er3.push_back(r); end
    else     begin eg.push_back(g);  if (with_rsp) er.push_back(r);  end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != '0) begin
        if (eg.size() == 0) chk("grant_unexpected", {grant, 3'b0, rom_addr}, 0);
        else chk("grant_addr", {grant, 3'b0, rom_addr}, eg.pop_front());
      end
      if (rsp_valid != '0) begin
        chk("rsp_latency", rsp_valid, prev_grant);
        if (er.size() == 0) chk("rsp_unexpected", {rsp_valid, 4'b0, rsp_data}, 0);
        else chk("rsp_data", {rsp_valid, 4'b0, rsp_data}, er.pop_front());
      end
      if (grant3 != '0) begin
        if (eg3.size() == 0) chk("grant3_unexpected", {grant3, 3'b0, rom_addr3}, 0);
        else chk("grant3_addr", {grant3, 3'b0, rom_addr3}, eg3.pop_front());
      end
      if (rsp_valid3 != '0) begin
        if (er3.size() == 0) chk("rsp3_unexpected", {rsp_valid3, 4'b0, rsp_data3}, 0);
        else chk("rsp3_data", {rsp_valid3, 4'b0, rsp_data3}, er3.pop_front());
      end
      if (overrun)  ovr_seen++;
      if (overrun3) ovr3_seen++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        if (eb.size() == 0) chk("busy_unexpected", busy_run, 0);
        else chk("busy_len", busy_run, eb.pop_front());
        busy_run = 0;
      end
      prev_grant = grant;
    end
  end

  // Opens a window, then sweeps x upward. rex re-hits DMA_START mid-line,
  // rst_at pulses reset in that cycle, tog is OR-ed into req two cycles in.
  task automatic run_line(input logic [3:0] r, input logic [3:0] r3, input int rex,
                          input int rst_at, input logic [3:0] tog);
    req  = r;
    req3 = r3;
    x    = -16'sd8;
    @(posedge clk); #1;
    for (int c = 1; c < 14; c++) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_grant", grant, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
      end
      x = (c == rex) ? -16'sd8 : CW'(-8 + c);
      if (c == 2) req = req | tog;
      rst = (c == rst_at);
      @(posedge clk); #1;
    end
    x = 16'sd100;
  endtask

  initial begin
    rst = 1'b1; x = 16'sd100; req = '0; req3 = '0;
    req_addr = {9'd32, 9'd24, 9'd16, 9'd8};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_grant3", grant3, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 4; s++) exp_g(s, 1, 0);
    eb.push_back(6);
    run_line(4'b1111, 4'b0000, 0, 0, 4'b0000);

    for (int s = 0; s < 4; s++) exp_g(s, 1, 0);
    eb.push_back(6);
    run_line(4'b1111, 4'b0000, 2, 0, 4'b0000);

    exp_g(1, 1, 0); eb.push_back(3);
    run_line(4'b0010, 4'b0000, 0, 0, 4'b0000);

    exp_g(3, 1, 0); exp_g(1, 1, 0); eb.push_back(4);
    run_line(4'b1010, 4'b0000, 0, 0, 4'b0000);

    eb.push_back(3);
    for (int s = 0; s < 3; s++) exp_g(s, 1, 1);
    run_line(4'b0000, 4'b1111, 0, 0, 4'b0000);
    chk("overrun3_pulses", ovr3_seen, 1);
    chk("pending3_idle", dut3.pending_q, 0);
    chk("busy3_idle", busy3, 0);

    exp_g(3, 1, 0); eb.push_back(3);
    run_line(4'b1000, 4'b0000, 0, 0, 4'b0000);

    exp_g(0, 1, 0); exp_g(1, 0, 0); eb.push_back(3);
    run_line(4'b1111, 4'b0000, 0, 3, 4'b0000);

    for (int s = 0; s < 4; s++) exp_g(s, 1, 0);
    eb.push_back(6);
    run_line(4'b1111, 4'b0000, 0, 0, 4'b0000);

    exp_g(0, 1, 0); eb.push_back(3);
    run_line(4'b0001, 4'b0000, 0, 0, 4'b0100);

    exp_g(2, 1, 0); eb.push_back(3);
    run_line(4'b0100, 4'b0000, 0, 0, 4'b0000);

    repeat (4) @(posedge clk);
    #1;
    chk("grants_left", eg.size(), 0);
    chk("rsps_left", er.size(), 0);
    chk("grants3_left", eg3.size(), 0);
    chk("rsps3_left", er3.size(), 0);
    chk("busy_left", eb.size(), 0);
    chk("overrun_main", ovr_seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
